// File: rtl/prng_pkg.sv
// Shared constants, types and command encoding for the 25-bit LCG generator.
package prng_pkg;

  localparam int unsigned PRNG_DAT_W = 25;

  typedef logic [PRNG_DAT_W-1:0] prng_word_t;

  localparam prng_word_t LCG_A    = prng_word_t'(1664525);
  localparam prng_word_t LCG_C    = prng_word_t'(12345);
  localparam prng_word_t RST_SEED = prng_word_t'(0);

  typedef enum logic [1:0] {
    PRNG_HALT = 2'd0,
    PRNG_STEP = 2'd1,
    PRNG_SEED = 2'd2,
    PRNG_RSVD = 2'd3
  } prng_cmd_e;

endpackage

// File: rtl/lcg_step.sv
// Combinational LCG update: y = (LCG_A*x + LCG_C) mod 2^PRNG_DAT_W.
module lcg_step
  import prng_pkg::*;
(
  input  prng_word_t x,
  output prng_word_t y
);

  // The low W bits of the full-width product and sum only depend on the low
  // W bits of each operand, so W-bit arithmetic gives the modulo result exactly.
  always_comb begin
    y = prng_word_t'((x * LCG_A) + LCG_C);
  end

endmodule

// File: rtl/prng_lcg_core.sv
// LCG pseudo-random source: one state register, stepped or seeded per command.
module prng_lcg_core
  import prng_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [1:0]            prng_typ_sel,
  input  logic                  prng_t_sel,
  input  logic [PRNG_DAT_W-1:0] prng_t_dat,
  output logic [PRNG_DAT_W-1:0] prng_r_dat
);

  prng_word_t x_q;
  prng_word_t x_d;
  prng_word_t x_next;
  prng_cmd_e  cmd;

  lcg_step u_lcg_step (
    .x (x_q),
    .y (x_next)
  );

  // Commands are unhandshaked: each one is accepted and completes on the edge
  // it is presented at; the result appears on prng_r_dat the following cycle.
  always_comb begin
    cmd = prng_cmd_e'(prng_typ_sel);
    x_d = x_q;
    case (cmd)
      PRNG_SEED: if (prng_t_sel) x_d = prng_t_dat;
      PRNG_STEP: x_d = x_next;
      default:   x_d = x_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      x_q <= RST_SEED;
    end else begin
      x_q <= x_d;
    end
  end

  assign prng_r_dat = x_q;

endmodule

// File: tb/tb_prng_lcg_core.sv
// Directed bench for prng_lcg_core with a 64-bit software LCG reference model.
module tb_prng_lcg_core;

  localparam int W = 25;
  localparam longint MASK = (64'd1 << W) - 64'd1;

  logic         clk;
  logic         rst_b;
  logic [1:0]   prng_typ_sel;
  logic         prng_t_sel;
  logic [W-1:0] prng_t_dat;
  logic [W-1:0] prng_r_dat;

  int total;
  int bad;
  logic [W-1:0] model;

  prng_lcg_core dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .prng_typ_sel (prng_typ_sel),
    .prng_t_sel   (prng_t_sel),
    .prng_t_dat   (prng_t_dat),
    .prng_r_dat   (prng_r_dat)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] lcg_model(input logic [W-1:0] x);
    longint p;
    p = (longint'(x) * 64'd1664525 + 64'd12345) & MASK;
    return p[W-1:0];
  endfunction

  // driver: present a command, let it take the next edge, settle past it
  task automatic drive(input logic rb, input logic [1:0] typ, input logic ts,
                       input logic [W-1:0] dat);
    rst_b        = rb;
    prng_typ_sel = typ;
    prng_t_sel   = ts;
    prng_t_dat   = dat;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_b = 1'b0;
    prng_typ_sel = 2'd0;
    prng_t_sel   = 1'b0;
    prng_t_dat   = '0;

    // 1. reset held for five cycles
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'd0, 1'b0, '0);
      chk("reset", prng_r_dat, 25'd0);
    end

    // 2. seed load then hold
    drive(1'b1, 2'd2, 1'b1, 25'd100);
    chk("seed100", prng_r_dat, 25'd100);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 1'b0, 25'd0);
      chk("hold100", prng_r_dat, 25'd100);
    end

    // no combinational path: inputs change, output does not until an edge
    prng_typ_sel = 2'd2;
    prng_t_sel   = 1'b1;
    prng_t_dat   = 25'd999;
    #2;
    chk("no_comb_path", prng_r_dat, 25'd100);

    // 3. single steps separated by holds
    drive(1'b1, 2'd1, 1'b0, 25'd0);
    chk("step1", prng_r_dat, 25'd32247117);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'd0, 1'b1, 25'd7);
      chk("hold_step1", prng_r_dat, 25'd32247117);
    end
    drive(1'b1, 2'd1, 1'b0, 25'd0);
    chk("step2", prng_r_dat, 25'd13536034);

    // 4. gated load and reserved opcode leave the state alone
    drive(1'b1, 2'd2, 1'b0, 25'd555);
    chk("gated_load", prng_r_dat, 25'd13536034);
    drive(1'b1, 2'd3, 1'b0, 25'd555);
    chk("rsvd_tsel0", prng_r_dat, 25'd13536034);
    drive(1'b1, 2'd3, 1'b1, 25'd555);
    chk("rsvd_tsel1", prng_r_dat, 25'd13536034);
    // t_sel is ignored on a step
    drive(1'b1, 2'd1, 1'b1, 25'd555);
    chk("step_tsel1", prng_r_dat, lcg_model(25'd13536034));

    // 5. wrap-around from all-ones seed
    drive(1'b1, 2'd2, 1'b1, 25'h1FF_FFFF);
    chk("seed_max", prng_r_dat, 25'h1FF_FFFF);
    drive(1'b1, 2'd1, 1'b0, 25'd0);
    chk("wrap_step", prng_r_dat, 25'd31902252);

    // 6. reset beats load and step
    drive(1'b0, 2'd2, 1'b1, 25'd777);
    chk("rst_over_seed", prng_r_dat, 25'd0);
    drive(1'b1, 2'd2, 1'b1, 25'd4321);
    chk("seed4321", prng_r_dat, 25'd4321);
    drive(1'b0, 2'd1, 1'b0, 25'd0);
    chk("rst_over_step", prng_r_dat, 25'd0);
    drive(1'b1, 2'd1, 1'b0, 25'd0);
    chk("step_after_rst", prng_r_dat, 25'd12345);

    // 1000 back-to-back steps against the model, with noise on unused inputs
    model = 25'd12345;
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 2'd1, 1'($urandom_range(0, 1)), 25'($urandom_range(0, 33554431)));
      model = lcg_model(model);
      chk("run_step", prng_r_dat, model);
    end

    // random seed followed by a short run
    model = 25'($urandom_range(0, 33554431));
    drive(1'b1, 2'd2, 1'b1, model);
    chk("rand_seed", prng_r_dat, model);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'd1, 1'b0, 25'd0);
      model = lcg_model(model);
      chk("rand_run", prng_r_dat, model);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
